// File: rtl/uart_slave.sv
// uart_slave: half-duplex sideband UART slave. Receives a framed command
// word from the master, publishes its payload, then replies with a framed
// status word after a fixed line turnaround.
// Ports: clk, rst (async, active-high), tick (baud strobe),
//   ser_in / ser_out / ser_oe (shared line, tristate at top level),
//   par_data_in (status to return), par_data_out (last good payload),
//   rx_valid / frame_error (1-clk pulses), err_cnt (saturating),
//   link_ok (good frame seen within TIMEOUT_BITS bit periods).
module uart_slave #(
   parameter int NBIT_RX         = 10,
   parameter int NBIT_TX         = 10,
   parameter int BPS_COUNT_NUM   = 48,
   parameter int START_COUNT_NUM = 24,
   parameter int TURN_BITS       = 4,
   parameter int TIMEOUT_BITS    = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               ser_in,
   output logic               ser_out,
   output logic               ser_oe,
   input  logic [NBIT_TX-1:0] par_data_in,
   output logic [NBIT_RX-1:0] par_data_out,
   output logic               rx_valid,
   output logic               frame_error,
   output logic [7:0]         err_cnt,
   output logic               link_ok
);

   localparam int RXW = NBIT_RX + 6;
   localparam int TXW = NBIT_TX + 6;
   localparam int CW  = $clog2(BPS_COUNT_NUM) + 1;
   localparam int BW  = $clog2(RXW + TXW + TURN_BITS);
   localparam int LW  = $clog2(TIMEOUT_BITS + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RX_START, S_RX_DATA, S_CHECK,
      S_TURN, S_TX_START, S_TX_DATA, S_TX_END
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [BW-1:0]      bit_q, bit_d;
   logic [RXW-1:0]     rx_q, rx_d;
   logic [TXW-1:0]     tx_q, tx_d;
   logic [NBIT_RX-1:0] par_q, par_d;
   logic               rxv_q, rxv_d;
   logic               ferr_q, ferr_d;
   logic [7:0]         err_q, err_d;
   logic [CW-1:0]      lpre_q;
   logic [LW-1:0]      lcnt_q;
   logic               link_q;
   logic               link_clr;
   logic               s1_q, s2_q, s3_q;
   logic               fall, per_done, st_done, good;

   // 2-FF synchronizer plus a delayed copy for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= ser_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign fall     = s3_q & ~s2_q;
   assign per_done = tick && (cnt_q == CW'(BPS_COUNT_NUM - 1));
   assign st_done  = tick && (cnt_q == CW'(START_COUNT_NUM - 1));
   assign good     = (rx_q[2:0] == 3'b101) &&
                     (rx_q[RXW-1:RXW-3] == 3'b010);

   always_comb begin
      state_d  = state_q;
      cnt_d    = tick ? cnt_q + CW'(1) : cnt_q;
      bit_d    = bit_q;
      rx_d     = rx_q;
      tx_d     = tx_q;
      par_d    = par_q;
      rxv_d    = 1'b0;
      ferr_d   = 1'b0;
      err_d    = err_q;
      link_clr = 1'b0;
      ser_oe   = 1'b0;
      ser_out  = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (fall) state_d = S_RX_START;
         end
         S_RX_START: begin
            if (st_done) begin
               cnt_d   = '0;
               state_d = s2_q ? S_IDLE : S_RX_DATA;
            end
         end
         S_RX_DATA: begin
            if (per_done) begin
               cnt_d = '0;
               // shift in from the top; first sample ends at bit 0
               rx_d  = {s2_q, rx_q[RXW-1:1]};
               if (bit_q == BW'(RXW - 1)) begin
                  bit_d   = '0;
                  state_d = S_CHECK;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         S_CHECK: begin
            cnt_d = '0;
            if (good) begin
               par_d    = rx_q[NBIT_RX+2:3];
               rxv_d    = 1'b1;
               link_clr = 1'b1;
               state_d  = S_TURN;
            end else begin
               ferr_d  = 1'b1;
               err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
               state_d = S_IDLE;
            end
         end
         S_TURN: begin
            if (per_done) begin
               cnt_d = '0;
               if (bit_q == BW'(TURN_BITS - 1)) begin
                  bit_d   = '0;
                  // status captured here so later changes miss this frame
                  tx_d    = {3'b010, par_data_in, 3'b101};
                  state_d = S_TX_START;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         S_TX_START: begin
            ser_oe  = 1'b1;
            ser_out = 1'b0;
            if (per_done) begin
               cnt_d   = '0;
               state_d = S_TX_DATA;
            end
         end
         S_TX_DATA: begin
            ser_oe  = 1'b1;
            ser_out = tx_q[0];
            if (per_done) begin
               cnt_d = '0;
               tx_d  = {1'b0, tx_q[TXW-1:1]};
               if (bit_q == BW'(TXW - 1)) begin
                  bit_d   = '0;
                  state_d = S_TX_END;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         S_TX_END: begin
            ser_oe  = 1'b1;
            ser_out = 1'b1;
            if (per_done) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         rx_q    <= '0;
         tx_q    <= '0;
         par_q   <= '0;
         rxv_q   <= 1'b0;
         ferr_q  <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         rx_q    <= rx_d;
         tx_q    <= tx_d;
         par_q   <= par_d;
         rxv_q   <= rxv_d;
         ferr_q  <= ferr_d;
         err_q   <= err_d;
      end
   end

   // link watchdog: free-running bit-period prescale, reset by good frames
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lpre_q <= '0;
         lcnt_q <= '0;
         link_q <= 1'b0;
      end else if (link_clr) begin
         lpre_q <= '0;
         lcnt_q <= '0;
         link_q <= 1'b1;
      end else if (tick) begin
         if (lpre_q == CW'(BPS_COUNT_NUM - 1)) begin
            lpre_q <= '0;
            if (lcnt_q != LW'(TIMEOUT_BITS)) begin
               lcnt_q <= lcnt_q + LW'(1);
               if (lcnt_q + LW'(1) == LW'(TIMEOUT_BITS))
                  link_q <= 1'b0;
            end
         end else begin
            lpre_q <= lpre_q + CW'(1);
         end
      end
   end

   assign par_data_out = par_q;
   assign rx_valid     = rxv_q;
   assign frame_error  = ferr_q;
   assign err_cnt      = err_q;
   assign link_ok      = link_q;

endmodule
